// File: rtl/mul22x15_arb.sv
// Round-robin arbiter sharing one external 22x15 signed multiplier.
// Optional MUL22X15_ARB_CHECK_EN adds a reference-product checker.
module mul22x15_arb #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*22-1:0]   req_a,
  input  logic [NREQ*15-1:0]   req_b,
  output logic [21:0]          mul_a,
  output logic [14:0]          mul_b,
  input  logic [35:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [35:0]          rsp_p,
  output logic                 busy
`ifdef MUL22X15_ARB_CHECK_EN
  ,
  output logic                 chk_err,
  output logic [35:0]          chk_exp
`endif
);

  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] id_r;
  logic [CW-1:0]  cnt;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            found;

  // Search starts one past the last winner, wrapping at NREQ.
  always_comb begin
    int j;
    j      = 0;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found  = 1'b1;
        gnt_id = IDW'(j);
      end
    end
    if (found) gnt[gnt_id] = 1'b1;
  end

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      id_r      <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            mul_a <= req_a[22*gnt_id +: 22];
            mul_b <= req_b[15*gnt_id +: 15];
            id_r  <= gnt_id;
            last  <= gnt_id;
            cnt   <= CW'(MUL_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rsp_p     <= mul_p;
            rsp_id    <= id_r;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL22X15_ARB_CHECK_EN
  logic signed [36:0] ref_p;
  assign ref_p = $signed({{15{mul_a[21]}}, mul_a})
               * $signed({{22{mul_b[14]}}, mul_b});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
      chk_exp <= '0;
    end else if (state == WAIT && cnt == '0) begin
      chk_exp <= ref_p[35:0];
      if (ref_p[35:0] != mul_p) chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mul22x15_arb.sv
// Directed bench for mul22x15_arb (NREQ=4, MUL_LAT=2).
// Define MUL22X15_ARB_CHECK_EN to also exercise the checker.
module tb_mul22x15_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*22-1:0] req_a;
  logic [NREQ*15-1:0] req_b;
  logic [21:0]       mul_a;
  logic [14:0]       mul_b;
  logic [35:0]       mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [35:0]       rsp_p;
  logic              busy;
  logic              corrupt = 1'b0;
`ifdef MUL22X15_ARB_CHECK_EN
  logic              chk_err;
  logic [35:0]       chk_exp;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operands are held through WAIT, so a combinational product
  // is valid by the time it is sampled.
  logic signed [36:0] full;
  assign full  = $signed({{15{mul_a[21]}}, mul_a})
               * $signed({{22{mul_b[14]}}, mul_b});
  assign mul_p = full[35:0] ^ {35'd0, corrupt};

  mul22x15_arb #(.NREQ(NREQ), .MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
`ifdef MUL22X15_ARB_CHECK_EN
    , .chk_err(chk_err), .chk_exp(chk_exp)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) return;
    end
    n = 99;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) return;
    end
    n = 99;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [35:0] prodf(input logic [21:0] a,
                                        input logic [14:0] b);
    logic signed [36:0] f;
    f = $signed({{15{a[21]}}, a}) * $signed({{22{b[14]}}, b});
    return f[35:0];
  endfunction

  task automatic do_op(input string tag, input int idx,
                       input logic [21:0] a, input logic [14:0] b,
                       input logic [35:0] p);
    int n;
    req_a[22*idx +: 22] = a;
    req_b[15*idx +: 15] = b;
    req_valid = oh(idx);
    wait_grant(n);
    chk({tag, ".gwait"}, 64'(n), 64'd1);
    chk({tag, ".ready"}, 64'(req_ready), 64'(oh(idx)));
    @(posedge clk); #1;
    req_valid = '0;
    req_a = '1;
    req_b = '1;
    chk({tag, ".mul_a"}, 64'(mul_a), 64'(a));
    chk({tag, ".mul_b"}, 64'(mul_b), 64'(b));
    wait_rsp(n);
    chk({tag, ".lat"}, 64'(n), 64'd3);
    chk({tag, ".id"}, 64'(rsp_id), 64'(idx));
    chk({tag, ".p"}, 64'(rsp_p), 64'(p));
    @(posedge clk); #1;
    chk({tag, ".idle"}, {62'd0, busy, rsp_valid}, 64'd0);
  endtask

  logic [21:0] ra [4];
  logic [14:0] rb [4];
  logic [35:0] rp [4];

  initial begin
    int n;
    int g0;
    logic seen;
    logic [21:0] xa;
    logic [14:0] xb;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst.out", {rsp_p, mul_a, 4'(req_ready)}, 64'd0);
    chk("rst.misc", {mul_b, 2'(rsp_id), rsp_valid, busy}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("single", 1, 22'd3, 15'd5, 36'h00000000F);
    do_op("neg", 0, 22'h3FFFFE, 15'd7, 36'hFFFFFFFF2);
    do_op("minmin", 2, 22'h200000, 15'h4000, 36'h800000000);
    do_op("maxmax", 3, 22'h1FFFFF, 15'h3FFF, 36'h7FFDFC001);

    ra[0] = 22'd10;     rb[0] = 15'd2;    rp[0] = 36'd20;
    ra[1] = 22'h3FFFFD; rb[1] = 15'd4;    rp[1] = 36'hFFFFFFFF4;
    ra[2] = 22'd100;    rb[2] = 15'h7FFF; rp[2] = 36'hFFFFFFF9C;
    ra[3] = 22'd1000;   rb[3] = 15'd1000; rp[3] = 36'h0000F4240;
    for (int i = 0; i < 4; i++) begin
      req_a[22*i +: 22] = ra[i];
      req_b[15*i +: 15] = rb[i];
    end
    req_valid = 4'b1111;
    g0 = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      chk("rr.grant", 64'(req_ready), 64'(oh(k % 4)));
      if (k > 0) chk("rr.gap", 64'(cyc - g0), 64'd5);
      g0 = cyc;
      @(posedge clk); #1;
      if (k == 4) req_valid = '0;
      wait_rsp(n);
      chk("rr.id", 64'(rsp_id), 64'(k % 4));
      chk("rr.p", 64'(rsp_p), 64'(rp[k % 4]));
    end
    @(posedge clk); #1;

    rsp_ready = 1'b0;
    req_a[22 +: 22] = 22'd7;
    req_b[15 +: 15] = 15'h7FF8;
    req_valid = 4'b0010;
    wait_grant(n);
    chk("bp.grant", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_rsp(n);
    chk("bp.lat", 64'(n), 64'd3);
    repeat (6) begin
      @(posedge clk); #1;
      chk("bp.hold", {rsp_p, 2'(rsp_id), rsp_valid, busy},
          {36'hFFFFFFFC8, 2'd1, 1'b1, 1'b1});
      chk("bp.noready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.hsready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("bp.idle", {62'd0, busy, rsp_valid}, 64'd0);
    chk("bp.next", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;
    @(posedge clk); #1;

    req_a[44 +: 22] = 22'd9;
    req_b[30 +: 15] = 15'd9;
    req_valid = 4'b0100;
    wait_grant(n);
    chk("rmo.grant", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rmo.async", {rsp_p, mul_a, 4'(req_ready)}, 64'd0);
    chk("rmo.misc", {mul_b, 2'(rsp_id), rsp_valid, busy}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= rsp_valid;
    end
    chk("rmo.norsp", 64'(seen), 64'd0);
    for (int i = 0; i < 4; i++) begin
      req_a[22*i +: 22] = ra[i];
      req_b[15*i +: 15] = rb[i];
    end
    req_valid = 4'b1111;
    wait_grant(n);
    chk("rmo.ptr", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(n);
    chk("rmo.p", 64'(rsp_p), 64'd20);
    @(posedge clk); #1;

`ifdef MUL22X15_ARB_CHECK_EN
    chk("ce.clean0", 64'(chk_err), 64'd0);
    for (int i = 0; i < 100; i++) begin
      xa = 22'($urandom);
      xb = 15'($urandom);
      do_op("ce.rand", i % 4, xa, xb, prodf(xa, xb));
      chk("ce.exp", 64'(chk_exp), 64'(prodf(xa, xb)));
    end
    chk("ce.clean", 64'(chk_err), 64'd0);
    corrupt = 1'b1;
    do_op("ce.bad", 1, 22'd3, 15'd5, 36'h00000000E);
    corrupt = 1'b0;
    chk("ce.set", 64'(chk_err), 64'd1);
    chk("ce.badexp", 64'(chk_exp), 64'h00000000F);
    do_op("ce.good", 2, 22'd3, 15'd5, 36'h00000000F);
    chk("ce.sticky", 64'(chk_err), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
